// File: rtl/id_stage_pipe.sv
// Decode stage of the 5-stage MIPS pipeline: IF/ID register, decoder, register file,
// ID-stage branch/jump resolution, load-use and branch hazard unit, and ID/EX register.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int RF_CLEAR = 1
) (
  input  logic            CLK,
  input  logic            nRESET,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic [4:0]      WriteRegE,
  input  logic            RegWriteM,
  input  logic            MemtoRegM,
  input  logic [4:0]      WriteRegM,
  input  logic [XLEN-1:0] ALUOutM,
  input  logic            RegWriteW,
  input  logic [4:0]      WriteRegW,
  input  logic [XLEN-1:0] ResultW,
  output logic            StallF,
  output logic [1:0]      PCSrcD,
  output logic [XLEN-1:0] PCBranchD,
  output logic [XLEN-1:0] PCJumpD,
  output logic            RegWriteE_o,
  output logic            MemtoRegE_o,
  output logic            MemWriteE_o,
  output logic            ALUSrcE_o,
  output logic            RegDstE_o,
  output logic [2:0]      ALUControlE,
  output logic [4:0]      RsE,
  output logic [4:0]      RtE,
  output logic [4:0]      RdE,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [XLEN-1:0] ImmE
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [31:0]     r_instrD;
  logic [XLEN-1:0] r_pcPlus4D;
  logic [XLEN-1:0] r_rf [32];

  logic            r_regWriteE, r_memtoRegE, r_memWriteE, r_aluSrcE, r_regDstE;
  logic [2:0]      r_aluCtlE;
  logic [4:0]      r_rsE, r_rtE, r_rdE;
  logic [XLEN-1:0] r_srcAE, r_srcBE, r_immE;

  logic [5:0]      w_op, w_funct;
  logic [4:0]      w_rs, w_rt, w_rd;
  logic [15:0]     w_imm;
  logic            w_regWrite, w_memtoReg, w_memWrite, w_aluSrc, w_regDst;
  logic [2:0]      w_aluCtl;
  logic            w_isBeq, w_isBne, w_isJ, w_rtRead, w_zeroExt;
  logic [XLEN-1:0] w_immSext, w_immExt;
  logic [XLEN-1:0] w_rfA, w_rfB, w_brA, w_brB;
  logic            w_rfWrEn, w_eq, w_lwStall, w_branchStall, w_stall, w_flushD;

  assign w_op    = r_instrD[31:26];
  assign w_rs    = r_instrD[25:21];
  assign w_rt    = r_instrD[20:16];
  assign w_rd    = r_instrD[15:11];
  assign w_funct = r_instrD[5:0];
  assign w_imm   = r_instrD[15:0];

  // Unknown opcodes fall through with every control low so they travel as bubbles.
  always_comb begin
    w_regWrite = 1'b0;
    w_memtoReg = 1'b0;
    w_memWrite = 1'b0;
    w_aluSrc   = 1'b0;
    w_regDst   = 1'b0;
    w_aluCtl   = 3'b000;
    w_isBeq    = 1'b0;
    w_isBne    = 1'b0;
    w_isJ      = 1'b0;
    w_rtRead   = 1'b0;
    w_zeroExt  = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_regDst   = 1'b1;
        w_rtRead   = 1'b1;
        w_regWrite = 1'b1;
        case (w_funct)
          F_ADD:   w_aluCtl = ALU_ADD;
          F_SUB:   w_aluCtl = ALU_SUB;
          F_AND:   w_aluCtl = ALU_AND;
          F_OR:    w_aluCtl = ALU_OR;
          F_SLT:   w_aluCtl = ALU_SLT;
          default: begin
            w_aluCtl   = ALU_ADD;
            w_regWrite = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        w_regWrite = 1'b1;
        w_memtoReg = 1'b1;
        w_aluSrc   = 1'b1;
        w_aluCtl   = ALU_ADD;
      end
      OP_SW: begin
        w_memWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_rtRead   = 1'b1;
        w_aluCtl   = ALU_ADD;
      end
      OP_BEQ: begin
        w_isBeq  = 1'b1;
        w_rtRead = 1'b1;
        w_aluCtl = ALU_SUB;
      end
      OP_BNE: begin
        w_isBne  = 1'b1;
        w_rtRead = 1'b1;
        w_aluCtl = ALU_SUB;
      end
      OP_ADDI: begin
        w_regWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_aluCtl   = ALU_ADD;
      end
      OP_ANDI: begin
        w_regWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_aluCtl   = ALU_AND;
        w_zeroExt  = 1'b1;
      end
      OP_ORI: begin
        w_regWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_aluCtl   = ALU_OR;
        w_zeroExt  = 1'b1;
      end
      OP_SLTI: begin
        w_regWrite = 1'b1;
        w_aluSrc   = 1'b1;
        w_aluCtl   = ALU_SLT;
      end
      OP_J:    w_isJ = 1'b1;
      default: w_isJ = 1'b0;
    endcase
  end

  assign w_immSext = {{(XLEN-16){w_imm[15]}}, w_imm};
  assign w_immExt  = w_zeroExt ? {{(XLEN-16){1'b0}}, w_imm} : w_immSext;

  // Entries at or above NREG are never written, so they stay constant and never reach a read port.
  assign w_rfWrEn = RegWriteW && (WriteRegW != 5'd0) && ({27'd0, WriteRegW} < 32'(NREG));

  generate
    if (RF_CLEAR != 0) begin : g_rfClear
      always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
          for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_rfWrEn) begin
          r_rf[WriteRegW] <= ResultW;
        end
      end
    end else begin : g_rfNoClear
      always_ff @(posedge CLK) begin
        if (w_rfWrEn) r_rf[WriteRegW] <= ResultW;
      end
    end
  endgenerate

  always_comb begin
    w_rfA = '0;
    w_rfB = '0;
    if ((w_rs != 5'd0) && ({27'd0, w_rs} < 32'(NREG)))
      w_rfA = (RegWriteW && (WriteRegW == w_rs)) ? ResultW : r_rf[w_rs];
    if ((w_rt != 5'd0) && ({27'd0, w_rt} < 32'(NREG)))
      w_rfB = (RegWriteW && (WriteRegW == w_rt)) ? ResultW : r_rf[w_rt];
  end

  assign w_brA = (RegWriteM && (WriteRegM == w_rs) && (w_rs != 5'd0)) ? ALUOutM : w_rfA;
  assign w_brB = (RegWriteM && (WriteRegM == w_rt) && (w_rt != 5'd0)) ? ALUOutM : w_rfB;
  assign w_eq  = (w_brA == w_brB);

  assign w_lwStall = MemtoRegE && (WriteRegE != 5'd0) &&
                     ((WriteRegE == w_rs) || ((WriteRegE == w_rt) && w_rtRead));
  assign w_branchStall = (w_isBeq || w_isBne) &&
      ((RegWriteE && (WriteRegE != 5'd0) && ((WriteRegE == w_rs) || (WriteRegE == w_rt))) ||
       (MemtoRegM && (WriteRegM != 5'd0) && ((WriteRegM == w_rs) || (WriteRegM == w_rt))));
  assign w_stall = w_lwStall || w_branchStall;
  assign StallF  = w_stall;

  // A stalled branch must not redirect: its operands are not final yet.
  always_comb begin
    PCSrcD = 2'b00;
    if (!w_stall) begin
      if ((w_isBeq && w_eq) || (w_isBne && !w_eq)) PCSrcD = 2'b01;
      else if (w_isJ)                              PCSrcD = 2'b10;
    end
  end

  assign w_flushD  = (PCSrcD != 2'b00);
  assign PCBranchD = r_pcPlus4D + {w_immSext[XLEN-3:0], 2'b00};
  assign PCJumpD   = {r_pcPlus4D[XLEN-1:28], r_instrD[25:0], 2'b00};

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_instrD   <= '0;
      r_pcPlus4D <= '0;
    end else if (w_flushD) begin
      r_instrD   <= '0;
      r_pcPlus4D <= '0;
    end else if (!w_stall) begin
      r_instrD   <= InstrF;
      r_pcPlus4D <= PCPlus4F;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET || w_stall) begin
      r_regWriteE <= 1'b0;
      r_memtoRegE <= 1'b0;
      r_memWriteE <= 1'b0;
      r_aluSrcE   <= 1'b0;
      r_regDstE   <= 1'b0;
      r_aluCtlE   <= 3'b000;
      r_rsE       <= '0;
      r_rtE       <= '0;
      r_rdE       <= '0;
      r_srcAE     <= '0;
      r_srcBE     <= '0;
      r_immE      <= '0;
    end else begin
      r_regWriteE <= w_regWrite;
      r_memtoRegE <= w_memtoReg;
      r_memWriteE <= w_memWrite;
      r_aluSrcE   <= w_aluSrc;
      r_regDstE   <= w_regDst;
      r_aluCtlE   <= w_aluCtl;
      r_rsE       <= w_rs;
      r_rtE       <= w_rt;
      r_rdE       <= w_rd;
      r_srcAE     <= w_rfA;
      r_srcBE     <= w_rfB;
      r_immE      <= w_immExt;
    end
  end

  assign RegWriteE_o = r_regWriteE;
  assign MemtoRegE_o = r_memtoRegE;
  assign MemWriteE_o = r_memWriteE;
  assign ALUSrcE_o   = r_aluSrcE;
  assign RegDstE_o   = r_regDstE;
  assign ALUControlE = r_aluCtlE;
  assign RsE         = r_rsE;
  assign RtE         = r_rtE;
  assign RdE         = r_rdE;
  assign SrcAE       = r_srcAE;
  assign SrcBE       = r_srcBE;
  assign ImmE        = r_immE;

endmodule
